// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the streaming FFT datapath.
// Packages cannot be parameterised, so each module declares its own
// {imag, real} pair struct at the width it needs.
package fft_pkg;

  // Phase of a single-delay-feedback butterfly stage.
  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMBINE = 2'd1,
    DRAIN   = 2'd2
  } sdf_state_e;

  // Frame position counter: counts 0 .. 2*stride-1.
  function automatic int cnt_width(input int stride);
    return $clog2(stride) + 1;
  endfunction

  // Delay-line address width; at least one bit so STRIDE=1 still has a port.
  function automatic int addr_width(input int stride);
    return (stride > 1) ? $clog2(stride) : 1;
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Single-port delay line for an SDF butterfly stage.
// Asynchronous read and synchronous write share one address, so a read and
// a write to the same entry in one cycle return the old contents.
module sdf_delay_line
  import fft_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 34,
  localparam int AW   = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  assign rdata_o = mem_q[addr_i];

  // Write port: store the entry addressed this cycle.
  // NOTE: the array has no reset; every entry is written before it is read,
  // and leaving it unreset lets it map onto distributed RAM. Sequential
  // state is always updated with <= so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/fft_sdf_butterfly.sv
// Radix-2 single-delay-feedback butterfly stage.
// Pairs sample n with sample n+STRIDE: emits STRIDE sums while the second
// half of a frame arrives, then the STRIDE stored differences either during
// the next frame's first half or, after s_last, in a dedicated drain phase.
module fft_sdf_butterfly
  import fft_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STRIDE = 4,
  parameter int SCALE  = 0,
  localparam int OW    = (SCALE != 0) ? WIDTH : WIDTH + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [2*WIDTH-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [2*OW-1:0]   m_data,
  output logic              m_last
);

  localparam int EW = WIDTH + 1;
  localparam int CW = cnt_width(STRIDE);
  localparam int AW = addr_width(STRIDE);

  localparam logic [CW-1:0] FILL_END = CW'(STRIDE - 1);
  localparam logic [CW-1:0] COMB_END = CW'(2 * STRIDE - 1);
  localparam logic [AW-1:0] ADDR_END = AW'(STRIDE - 1);

  typedef struct packed {
    logic signed [EW-1:0] im;
    logic signed [EW-1:0] re;
  } cplx_ext_t;

  typedef struct packed {
    logic signed [OW-1:0] im;
    logic signed [OW-1:0] re;
  } cplx_out_t;

  // Optional halving (arithmetic shift, floor) down to the output width.
  function automatic logic signed [OW-1:0] scale(input logic signed [EW-1:0] v);
    logic signed [EW-1:0] s;
    s = (SCALE != 0) ? (v >>> 1) : v;
    return s[OW-1:0];
  endfunction

  sdf_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] dcnt_q, dcnt_d;
  logic          pending_q, pending_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  cplx_out_t     m_data_q, m_data_d;

  logic          adv;
  logic          accept;
  logic [AW-1:0] cnt_addr;
  logic [AW-1:0] addr;
  logic          we;
  cplx_ext_t     in_ext;
  cplx_ext_t     rd;
  cplx_ext_t     wdata;
  cplx_ext_t     res;
  logic          res_valid;
  logic          res_last;

  // The output register may load whenever it is empty or being emptied.
  assign adv      = !m_valid_q || m_ready;
  assign s_ready  = adv && (state_q != DRAIN);
  assign accept   = s_valid && s_ready;

  assign in_ext.re = {s_data[WIDTH-1], s_data[WIDTH-1:0]};
  assign in_ext.im = {s_data[2*WIDTH-1], s_data[2*WIDTH-1:WIDTH]};

  // Position within the current half-frame; always 0 for a span of one.
  assign cnt_addr = (STRIDE == 1) ? '0 : cnt_q[AW-1:0];

  sdf_delay_line #(
    .DEPTH (STRIDE),
    .DW    (2 * EW)
  ) u_delay (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rd)
  );

  // Phase sequencing, delay-line access and butterfly arithmetic.
  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    pending_d = pending_q;
    addr      = cnt_addr;
    we        = 1'b0;
    wdata     = in_ext;
    res       = rd;
    res_valid = 1'b0;
    res_last  = 1'b0;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          // Store the first operand; hand out the previous frame's difference.
          we        = 1'b1;
          res_valid = pending_q;
          res_last  = pending_q && (cnt_addr == ADDR_END);
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == FILL_END) begin
            state_d   = COMBINE;
            pending_d = 1'b0;
          end
        end
      end

      COMBINE: begin
        if (accept) begin
          we        = 1'b1;
          res.re    = rd.re + in_ext.re;
          res.im    = rd.im + in_ext.im;
          wdata.re  = rd.re - in_ext.re;
          wdata.im  = rd.im - in_ext.im;
          res_valid = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == COMB_END) begin
            pending_d = 1'b1;
            if (s_last) begin
              state_d = DRAIN;
              dcnt_d  = '0;
            end else begin
              state_d = FILL;
            end
          end
        end
      end

      DRAIN: begin
        addr = dcnt_q;
        if (adv) begin
          res_valid = 1'b1;
          res_last  = (dcnt_q == ADDR_END);
          if (dcnt_q == ADDR_END) begin
            state_d   = FILL;
            cnt_d     = '0;
            pending_d = 1'b0;
            dcnt_d    = '0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Output register: loads on advance, holds while stalled.
  always_comb begin
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    if (adv) begin
      m_valid_d   = res_valid;
      m_last_d    = res_last;
      m_data_d.re = scale(res.re);
      m_data_d.im = scale(res.im);
    end
  end

  // Control state and handshake flags with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      pending_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      pending_q <= pending_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  // Output payload; qualified by m_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    m_data_q <= m_data_d;
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;

endmodule
